rot_sequencer: RTL and testbench

//  Fixed-point 2-D rotation sequencer feeding the shared 16x16 signed Booth multiplier.

---
 rtl/rot_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_rot_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rot_sequencer.sv
// rot_sequencer: 2-D fixed-point rotation issued as four serial products on a shared multiplier.
// Define ROT_SAT_EN to saturate the rescaled result; by default it wraps to W bits.
module rot_sequencer #(
  parameter int W           = 16,
  parameter int FRAC        = 14,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   x_in,
  input  logic [W-1:0]   y_in,
  input  logic [W-1:0]   cos_in,
  input  logic [W-1:0]   sin_in,
  output logic           mul_en,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic           mul_busy,
  input  logic [2*W-1:0] mul_r,
  output logic           out_valid,
  output logic [W-1:0]   out_x,
  output logic [W-1:0]   out_y,
  output logic           err
);

  localparam int AW = 2*W + 2;
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_ACK  = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_ACCUM     = 3'd4;
  localparam logic [2:0] S_OUT       = 3'd5;

  logic [2:0]             state;
  logic [W-1:0]           x_r, y_r, cos_r, sin_r;
  logic [1:0]             idx;
  logic [1:0]             idx_next;
  logic [CW-1:0]          ack_cnt;
  logic [2*W-1:0]         prod_r;
  logic signed [AW-1:0]   prod_ext;
  logic signed [AW-1:0]   acc_x, acc_y;
  logic signed [AW-1:0]   acc_x_nxt, acc_y_nxt;
  logic [W-1:0]           next_a, next_b;
  logic [W-1:0]           res_x, res_y;

  assign in_ready = (state == S_IDLE);
  assign prod_ext = {{2{prod_r[2*W-1]}}, prod_r};
  assign idx_next = idx + 2'd1;

  // Products 0/1 form x' (x*cos - y*sin), products 2/3 form y' (x*sin + y*cos).
  always_comb begin
    acc_x_nxt = acc_x;
    acc_y_nxt = acc_y;
    case (idx)
      2'd0:    acc_x_nxt = acc_x + prod_ext;
      2'd1:    acc_x_nxt = acc_x - prod_ext;
      default: acc_y_nxt = acc_y + prod_ext;
    endcase
  end

  always_comb begin
    next_a = x_r;
    next_b = cos_r;
    case (idx_next)
      2'd0:    begin next_a = x_r; next_b = cos_r; end
      2'd1:    begin next_a = y_r; next_b = sin_r; end
      2'd2:    begin next_a = x_r; next_b = sin_r; end
      default: begin next_a = y_r; next_b = cos_r; end
    endcase
  end

`ifdef ROT_SAT_EN
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  logic signed [AW-1:0] sh_x, sh_y;

  always_comb begin
    sh_x  = acc_x_nxt >>> FRAC;
    sh_y  = acc_y_nxt >>> FRAC;
    res_x = sh_x[W-1:0];
    res_y = sh_y[W-1:0];
    if (sh_x > SAT_MAX)      res_x = SAT_MAX[W-1:0];
    else if (sh_x < SAT_MIN) res_x = SAT_MIN[W-1:0];
    if (sh_y > SAT_MAX)      res_y = SAT_MAX[W-1:0];
    else if (sh_y < SAT_MIN) res_y = SAT_MIN[W-1:0];
  end
`else
  // Floor shift then wrap is just a bit-field pick out of the accumulator.
  always_comb begin
    res_x = acc_x_nxt[FRAC +: W];
    res_y = acc_y_nxt[FRAC +: W];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      x_r       <= '0;
      y_r       <= '0;
      cos_r     <= '0;
      sin_r     <= '0;
      idx       <= '0;
      ack_cnt   <= '0;
      prod_r    <= '0;
      acc_x     <= '0;
      acc_y     <= '0;
      mul_en    <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      err       <= 1'b0;
    end else begin
      mul_en    <= 1'b0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            x_r    <= x_in;
            y_r    <= y_in;
            cos_r  <= cos_in;
            sin_r  <= sin_in;
            mul_a  <= x_in;
            mul_b  <= cos_in;
            mul_en <= 1'b1;
            idx    <= '0;
            acc_x  <= '0;
            acc_y  <= '0;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          ack_cnt <= '0;
          state   <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (mul_busy) begin
            state <= S_WAIT_DONE;
          end else if (ack_cnt == CW'(ACK_TIMEOUT - 1)) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            ack_cnt <= ack_cnt + CW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!mul_busy) begin
            prod_r <= mul_r;
            state  <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          acc_x <= acc_x_nxt;
          acc_y <= acc_y_nxt;
          idx   <= idx_next;
          if (idx == 2'd3) begin
            out_x     <= res_x;
            out_y     <= res_y;
            out_valid <= 1'b1;
            state     <= S_OUT;
          end else begin
            mul_a  <= next_a;
            mul_b  <= next_b;
            mul_en <= 1'b1;
            state  <= S_ISSUE;
          end
        end
        S_OUT:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rot_sequencer.sv
// tb_rot_sequencer: scoreboard bench for rot_sequencer with a behavioural multiplier model.
// Expected results follow ROT_SAT_EN the same way the design does.
module tb_rot_sequencer;

  localparam int W           = 16;
  localparam int FRAC        = 14;
  localparam int ACK_TIMEOUT = 8;
  localparam int MUL_LAT     = 3;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [W-1:0]          x_in = '0, y_in = '0, cos_in = '0, sin_in = '0;
  logic                  mul_en;
  logic [W-1:0]          mul_a, mul_b;
  logic                  mul_busy;
  logic signed [2*W-1:0] mul_r;
  logic                  out_valid;
  logic [W-1:0]          out_x, out_y;
  logic                  err;

  int    checks = 0;
  int    errors = 0;
  int    out_count = 0;
  int    mul_en_count = 0;
  int    err_count = 0;
  logic  hang = 1'b0;
  string cur_tag = "reset";
  int    exp_x_q[$];
  int    exp_y_q[$];

  always #5 clk = ~clk;

  rot_sequencer #(.W(W), .FRAC(FRAC), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .cos_in(cos_in), .sin_in(sin_in),
    .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b),
    .mul_busy(mul_busy), .mul_r(mul_r),
    .out_valid(out_valid), .out_x(out_x), .out_y(out_y), .err(err)
  );

  // Multiplier model: busy for MUL_LAT cycles after a start, product valid as busy drops.
  logic [3:0]          mcnt;
  logic signed [W-1:0] ma, mb;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_busy <= 1'b0;
      mul_r    <= '0;
      mcnt     <= '0;
      ma       <= '0;
      mb       <= '0;
    end else if (mul_busy) begin
      if (mcnt == 0) begin
        mul_busy <= 1'b0;
        mul_r    <= ma * mb;
      end else begin
        mcnt <= mcnt - 4'd1;
      end
    end else if (mul_en && !hang) begin
      mul_busy <= 1'b1;
      mcnt     <= 4'(MUL_LAT - 1);
      ma       <= mul_a;
      mb       <= mul_b;
    end
  end

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int rot_model(input longint acc);
    longint sh;
    sh = acc >>> FRAC;
`ifdef ROT_SAT_EN
    if (sh > 32767)  return 32767;
    if (sh < -32768) return -32768;
    return int'(sh);
`else
    return int'(shortint'(sh));
`endif
  endfunction

  // Output monitor: every out_valid pops one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mul_en) mul_en_count++;
      if (err)    err_count++;
      if (out_valid) begin
        out_count++;
        if (exp_x_q.size() > 0) begin
          checkOutput({cur_tag, "_out_x"}, $signed(out_x), exp_x_q.pop_front());
          checkOutput({cur_tag, "_out_y"}, $signed(out_y), exp_y_q.pop_front());
        end else begin
          checkOutput({cur_tag, "_spurious_out_valid"}, out_valid, 0);
        end
      end
    end
  end

  task automatic applyStimulus(input int x, input int y, input int c, input int s,
                               input bit push, input int ex, input int ey);
    int n;
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) checkOutput({cur_tag, "_ready_timeout"}, in_ready, 1);
    x_in     = W'(x);
    y_in     = W'(y);
    cos_in   = W'(c);
    sin_in   = W'(s);
    in_valid = 1'b1;
    if (push) begin
      exp_x_q.push_back(ex);
      exp_y_q.push_back(ey);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    int n;
    n = 0;
    while ((exp_x_q.size() != 0 || !in_ready) && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_x_q.size() != 0) begin
      checkOutput({tag, "_drain_timeout"}, exp_x_q.size(), 0);
      exp_x_q.delete();
      exp_y_q.delete();
    end
  endtask

  initial begin
    int x, y, c, s, n, snap;

    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready",  in_ready,  1);
    checkOutput("rst_mul_en",    mul_en,    0);
    checkOutput("rst_mul_a",     mul_a,     0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_x",     out_x,     0);
    checkOutput("rst_err",       err,       0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    cur_tag = "t1_identity";
    mul_en_count = 0;
    applyStimulus(100, 0, 16384, 0, 1'b1, 100, 0);
    waitDrain(cur_tag);
    checkOutput("t1_mul_en_pulses", mul_en_count, 4);

    // A request held while busy must be dropped, not queued.
    cur_tag = "t2_quarter";
    applyStimulus(100, 0, 0, 16384, 1'b1, 0, 100);
    x_in = W'(1234); y_in = W'(-77); in_valid = 1'b1;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    waitDrain(cur_tag);

    cur_tag = "t3_floor";
    applyStimulus(-200, 50, 11585, 11585, 1'b1, -177, -107);
    waitDrain(cur_tag);

    cur_tag = "t4_overflow";
`ifdef ROT_SAT_EN
    applyStimulus(32767, 32767, 16384, 16384, 1'b1, 0, 32767);
`else
    applyStimulus(32767, 32767, 16384, 16384, 1'b1, 0, -2);
`endif
    waitDrain(cur_tag);

    cur_tag = "rand";
    for (int i = 0; i < 8; i++) begin
      x = int'($urandom_range(0, 65535)) - 32768;
      y = int'($urandom_range(0, 65535)) - 32768;
      c = int'($urandom_range(0, 32768)) - 16384;
      s = int'($urandom_range(0, 32768)) - 16384;
      applyStimulus(x, y, c, s, 1'b1,
                    rot_model(longint'(x) * c - longint'(y) * s),
                    rot_model(longint'(x) * s + longint'(y) * c));
    end
    waitDrain(cur_tag);

    cur_tag = "t5_timeout";
    hang = 1'b1;
    err_count = 0;
    snap = out_count;
    applyStimulus(10, 20, 16384, 0, 1'b0, 0, 0);
    n = 0;
    while (!mul_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t5_mul_en_seen", mul_en, 1);
    n = 0;
    while (!err && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t5_err_delay", n, ACK_TIMEOUT + 1);
    checkOutput("t5_in_ready", in_ready, 1);
    repeat (5) @(negedge clk);
    #1;
    checkOutput("t5_err_pulses", err_count, 1);
    checkOutput("t5_no_out", out_count - snap, 0);
    hang = 1'b0;

    cur_tag = "t6_reset";
    applyStimulus(1000, -500, 11585, 11585, 1'b0, 0, 0);
    n = 0;
    while (!mul_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_out_x",     out_x,     0);
    checkOutput("t6_out_y",     out_y,     0);
    checkOutput("t6_out_valid", out_valid, 0);
    checkOutput("t6_mul_a",     mul_a,     0);
    checkOutput("t6_mul_b",     mul_b,     0);
    checkOutput("t6_mul_en",    mul_en,    0);
    checkOutput("t6_in_ready",  in_ready,  1);
    snap = out_count;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("t6_discarded", out_count - snap, 0);
    cur_tag = "t6_after";
    applyStimulus(300, -40, 0, 16384, 1'b1, 40, 300);
    waitDrain(cur_tag);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
